error_stats_heatmap: RTL and testbench
======================================

Name: error_stats_heatmap

Overview:
Parametrised multi-channel error aggregator for the SDRAM stress-test top. It takes per-port error strobes and error-bit vectors from N port testers, and maintains four things per channel:
- decaying per-bit heat values, read by the video pixel path;
- cumulative error-bit masks;
- saturating event and bit-error counters.
It also offers a req/ack readback interface for the JTAG debug bridge. It generalises channel count, data width, heat depth, decay step and counter width, and adds bit-error popcount, live clear and range checking.

Parameters:
CHANNELS, 5, number of ports under test (1..16)
DATAWIDTH, 16, error-bit vector width per channel (1..32)
HEATBITS, 8, width of each heat cell
DECAY_STEP, 1, amount subtracted from each nonzero heat cell per decay strobe
COUNTWIDTH, 32, width of event and bit-error counters (<=32)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
err  in  CHANNELS  per-channel error strobe, one cycle per failed compare
errbits  in  CHANNELS*DATAWIDTH  channel c occupies [c*DATAWIDTH +: DATAWIDTH]; sampled when err[c]=1
decay_stb  in  1  decay tick, normally vblank strobe
clear  in  1  synchronous clear of counters and masks
hm_idx  in  clog2(CHANNELS*DATAWIDTH)  heat cell index = c*DATAWIDTH+bit
hm_q  out  HEATBITS  heat value of hm_idx, registered
rd_req  in  1  readback request
rd_chan  in  4  channel to read
rd_sel  in  2  0 event count, 1 bit-error count, 2 cumulative mask, 3 geometry
rd_ack  out  1  one-cycle pulse; rd_q valid in the same cycle
rd_q  out  32  readback data
any_err  out  1  sticky: at least one error since reset/clear

Behaviour:
- Reset (clk edge with reset=1) clears all of the following to 0: heat cells, masks, counters, hm_q, rd_ack, rd_q, any_err. The readback FSM goes to IDLE.
- Heat update per cell, per cycle, in priority order:
  - If err[c] and errbits bit set: load all-ones.
  - Else if decay_stb and cell != 0: cell = max(cell - DECAY_STEP, 0), saturating, never wraps.
  - Else: hold.
  - Error load beats decay in the same cycle.
  - clear does not affect heat cells.
- Cumulative mask[c] |= errbits[c] when err[c]=1.
- Event count[c] increments by 1 on err[c], saturating at all-ones. This holds even if errbits[c]=0.
- Bit-error count[c] adds popcount(errbits[c]) on err[c], saturating at all-ones; overflow clamps, it does not wrap.
- clear=1 zeroes masks, counters and any_err at the next edge. clear wins over err in the same cycle: that cycle's mask and count contribution is dropped, but its heat load still occurs.
- any_err is set on any err bit when clear=0.
- Pixel path:
  - hm_q = heat[hm_idx] one cycle after hm_idx is presented.
  - An hm_idx >= CHANNELS*DATAWIDTH gives hm_q=0.
  - A heat update in cycle N is visible on hm_q at N+1 at the earliest, i.e. registered read of pre-update value.
- Readback FSM, states IDLE and ACK:
  - IDLE and rd_req=1: latch the selected value into rd_q, go to ACK. The snapshot is taken at the accept edge, so later updates do not alter rd_q.
  - ACK: rd_ack=1 for exactly one cycle, then IDLE. rd_req is ignored in ACK, so a held rd_req yields an ack every 2nd cycle.
  - rd_q holds its value after ack until the next accept.
  - rd_chan >= CHANNELS returns 0.
  - Sel 2 returns the mask zero-extended.
  - Sel 3 returns {16'h0, CHANNELS[7:0], DATAWIDTH[7:0]}.
  - Counters are zero-extended to 32 bits.
- Reset mid-read drops the pending ack; no ack pulse is emitted.

Test Plan:
- Reset then idle; read ch0 sel0/1/2 -> rd_q=0 each time, and rd_ack pulses exactly 1 cycle, 1 cycle after accept.
- err[2]=1 with errbits ch2=16'h8001 for 3 pulses -> ch2 sel0=3, sel1=6, sel2=0x8001. heat[32] and heat[47]=0xFF; other cells 0; any_err=1.
- After a heat load, 10 decay_stb pulses -> hm_q for idx 32 reads 0xF5. With DECAY_STEP=4 and 64 strobes the cell reaches 0 and stays 0, with no wrap.
- err and decay_stb in the same cycle on bit 0 of ch1 -> cell reads 0xFF; err plus clear in the same cycle -> counters 0, mask 0, any_err 0, heat still 0xFF.
- COUNTWIDTH=4, 20 err pulses with errbits=16'hFFFF -> sel0=15 and sel1=15, both saturated.
- Hold rd_req=1 for 6 cycles with rd_chan=7 -> 3 ack pulses, rd_q=0; rd_sel=3 -> 0x0510. Assert reset during ACK -> no ack pulse, and rd_q=0.

Source files
------------

// File: rtl/error_stats_heatmap.sv
// Multi-channel error aggregator for the SDRAM stress-test top.
// Tracks per-bit decaying heat values for the video pixel path, and keeps
// cumulative error masks plus saturating event and bit-error counters per
// channel. A req/ack readback port serves the JTAG debug bridge.
//
// Readback FSM:
//   state  | meaning
//   S_IDLE | waiting for rd_req_i; accepts and snapshots the selected value
//   S_ACK  | rd_ack_o high for this one cycle; rd_req_i ignored
module error_stats_heatmap #(
    parameter int CHANNELS   = 5,
    parameter int DATAWIDTH  = 16,
    parameter int HEATBITS   = 8,
    parameter int DECAY_STEP = 1,
    parameter int COUNTWIDTH = 32,
    localparam int NCELLS    = CHANNELS * DATAWIDTH,
    localparam int IDXW      = (NCELLS > 1) ? $clog2(NCELLS) : 1
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic [CHANNELS-1:0]           err_i,
    input  logic [CHANNELS*DATAWIDTH-1:0] errbits_i,
    input  logic                          decay_stb_i,
    input  logic                          clear_i,
    input  logic [IDXW-1:0]               hm_idx_i,
    output logic [HEATBITS-1:0]           hm_q_o,
    input  logic                          rd_req_i,
    input  logic [3:0]                    rd_chan_i,
    input  logic [1:0]                    rd_sel_i,
    output logic                          rd_ack_o,
    output logic [31:0]                   rd_q_o,
    output logic                          any_err_o
);

    // Parameter ranges the datapath is sized for; anything else is rejected
    // at elaboration rather than silently truncated.
    if (CHANNELS < 1 || CHANNELS > 16) begin : g_bad_channels
        $error("error_stats_heatmap: CHANNELS must be 1..16");
    end
    if (DATAWIDTH < 1 || DATAWIDTH > 32) begin : g_bad_datawidth
        $error("error_stats_heatmap: DATAWIDTH must be 1..32");
    end
    if (HEATBITS < 1 || HEATBITS > 32) begin : g_bad_heatbits
        $error("error_stats_heatmap: HEATBITS must be 1..32");
    end
    if (COUNTWIDTH < 1 || COUNTWIDTH > 32) begin : g_bad_countwidth
        $error("error_stats_heatmap: COUNTWIDTH must be 1..32");
    end
    if (DECAY_STEP < 1) begin : g_bad_decay
        $error("error_stats_heatmap: DECAY_STEP must be >= 1");
    end

    // Counter ceiling held 33 bits wide so sum-versus-ceiling compares never
    // overflow, even with COUNTWIDTH=32 and a full-width popcount added.
    localparam logic [32:0] CNT_MAX33 = (33'd1 << COUNTWIDTH) - 33'd1;
    localparam logic [31:0] GEOMETRY  = {16'h0, 8'(CHANNELS), 8'(DATAWIDTH)};

    typedef enum logic {
        S_IDLE = 1'b0,
        S_ACK  = 1'b1
    } rd_state_t;

    function automatic logic [5:0] popcount(input logic [DATAWIDTH-1:0] v);
        logic [5:0] n;
        n = '0;
        for (int i = 0; i < DATAWIDTH; i++) begin
            n = n + 6'(v[i]);
        end
        return n;
    endfunction

    logic [HEATBITS-1:0]   heat_q [NCELLS];
    logic [HEATBITS-1:0]   heat_d [NCELLS];
    logic [DATAWIDTH-1:0]  mask_q [CHANNELS];
    logic [DATAWIDTH-1:0]  mask_d [CHANNELS];
    logic [COUNTWIDTH-1:0] evt_q  [CHANNELS];
    logic [COUNTWIDTH-1:0] evt_d  [CHANNELS];
    logic [COUNTWIDTH-1:0] bit_q  [CHANNELS];
    logic [COUNTWIDTH-1:0] bit_d  [CHANNELS];
    logic                  any_err_q;
    logic                  any_err_d;
    logic [HEATBITS-1:0]   hm_q;
    rd_state_t             rd_state_q;
    logic                  rd_ack_q;
    logic [31:0]           rd_q;
    logic [31:0]           rd_val;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        for (genvar b = 0; b < DATAWIDTH; b++) begin : g_cell
            localparam int IDX = c * DATAWIDTH + b;

            // Heat cell: error load outranks decay; decay saturates at zero.
            // clear_i intentionally leaves heat alone so the display persists.
            always_comb begin
                heat_d[IDX] = heat_q[IDX];
                if (err_i[c] && errbits_i[IDX]) begin
                    heat_d[IDX] = '1;
                end else if (decay_stb_i && (heat_q[IDX] != '0)) begin
                    if (32'(heat_q[IDX]) > 32'(DECAY_STEP)) begin
                        heat_d[IDX] = heat_q[IDX] - HEATBITS'(DECAY_STEP);
                    end else begin
                        heat_d[IDX] = '0;
                    end
                end
            end
        end

        // Mask and counters: clear drops this cycle's contribution entirely.
        always_comb begin
            logic [DATAWIDTH-1:0] bits;
            logic [32:0]          sum;
            bits      = errbits_i[c*DATAWIDTH +: DATAWIDTH];
            sum       = 33'(bit_q[c]) + 33'(popcount(bits));
            mask_d[c] = mask_q[c];
            evt_d[c]  = evt_q[c];
            bit_d[c]  = bit_q[c];
            if (clear_i) begin
                mask_d[c] = '0;
                evt_d[c]  = '0;
                bit_d[c]  = '0;
            end else if (err_i[c]) begin
                mask_d[c] = mask_q[c] | bits;
                if (evt_q[c] != '1) begin
                    evt_d[c] = evt_q[c] + COUNTWIDTH'(1);
                end
                bit_d[c] = (sum > CNT_MAX33) ? CNT_MAX33[COUNTWIDTH-1:0]
                                             : sum[COUNTWIDTH-1:0];
            end
        end
    end

    // Sticky error flag, cleared by clear_i which also wins over new errors.
    always_comb begin
        any_err_d = any_err_q;
        if (clear_i) begin
            any_err_d = 1'b0;
        end else if (|err_i) begin
            any_err_d = 1'b1;
        end
    end

    // Register heat, masks, counters and the sticky flag.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < NCELLS; i++) begin
                heat_q[i] <= '0;
            end
            for (int c = 0; c < CHANNELS; c++) begin
                mask_q[c] <= '0;
                evt_q[c]  <= '0;
                bit_q[c]  <= '0;
            end
            any_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < NCELLS; i++) begin
                heat_q[i] <= heat_d[i];
            end
            for (int c = 0; c < CHANNELS; c++) begin
                mask_q[c] <= mask_d[c];
                evt_q[c]  <= evt_d[c];
                bit_q[c]  <= bit_d[c];
            end
            any_err_q <= any_err_d;
        end
    end

    // Pixel path: registered read of the pre-update heat value; indices past
    // the last cell read as zero.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            hm_q <= '0;
        end else if (32'(hm_idx_i) < 32'(NCELLS)) begin
            hm_q <= heat_q[hm_idx_i];
        end else begin
            hm_q <= '0;
        end
    end

    // Readback mux; out-of-range channels read as zero for every select.
    always_comb begin
        rd_val = '0;
        if (32'(rd_chan_i) < 32'(CHANNELS)) begin
            case (rd_sel_i)
                2'd0:    rd_val = 32'(evt_q[rd_chan_i]);
                2'd1:    rd_val = 32'(bit_q[rd_chan_i]);
                2'd2:    rd_val = 32'(mask_q[rd_chan_i]);
                default: rd_val = GEOMETRY;
            endcase
        end
    end

    // Readback FSM: snapshot at accept, single-cycle ack, then back to idle.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rd_state_q <= S_IDLE;
            rd_ack_q   <= 1'b0;
            rd_q       <= '0;
        end else begin
            case (rd_state_q)
                S_IDLE: begin
                    if (rd_req_i) begin
                        rd_q       <= rd_val;
                        rd_ack_q   <= 1'b1;
                        rd_state_q <= S_ACK;
                    end else begin
                        rd_ack_q <= 1'b0;
                    end
                end
                default: begin
                    rd_ack_q   <= 1'b0;
                    rd_state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign hm_q_o    = hm_q;
    assign rd_ack_o  = rd_ack_q;
    assign rd_q_o    = rd_q;
    assign any_err_o = any_err_q;

endmodule

// File: tb/tb_error_stats_heatmap.sv
// Directed bench for error_stats_heatmap. Two instances share stimulus: the
// default configuration and a narrow one (COUNTWIDTH=4, DECAY_STEP=4) used
// for the saturation and decay-floor cases.
module tb_error_stats_heatmap;

    localparam int CH = 5;
    localparam int DW = 16;

    logic           clk = 1'b0;
    logic           reset;
    logic [CH-1:0]  err;
    logic [CH*DW-1:0] errbits;
    logic           decay_stb;
    logic           clear;
    logic [6:0]     hm_idx;
    logic           rd_req;
    logic [3:0]     rd_chan;
    logic [1:0]     rd_sel;

    logic [7:0]     hm_a, hm_b;
    logic           ack_a, ack_b;
    logic [31:0]    rdq_a, rdq_b;
    logic           any_a, any_b;

    int compared   = 0;
    int mismatched = 0;
    int acks;

    error_stats_heatmap u_dut (
        .clk_i(clk), .reset_i(reset), .err_i(err), .errbits_i(errbits),
        .decay_stb_i(decay_stb), .clear_i(clear), .hm_idx_i(hm_idx),
        .hm_q_o(hm_a), .rd_req_i(rd_req), .rd_chan_i(rd_chan),
        .rd_sel_i(rd_sel), .rd_ack_o(ack_a), .rd_q_o(rdq_a), .any_err_o(any_a)
    );

    error_stats_heatmap #(.COUNTWIDTH(4), .DECAY_STEP(4)) u_sat (
        .clk_i(clk), .reset_i(reset), .err_i(err), .errbits_i(errbits),
        .decay_stb_i(decay_stb), .clear_i(clear), .hm_idx_i(hm_idx),
        .hm_q_o(hm_b), .rd_req_i(rd_req), .rd_chan_i(rd_chan),
        .rd_sel_i(rd_sel), .rd_ack_o(ack_b), .rd_q_o(rdq_b), .any_err_o(any_b)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_read(input string tag, input logic [3:0] ch, input logic [1:0] sel,
                           input logic [31:0] exp_a, input logic [31:0] exp_b);
        rd_req  = 1'b1;
        rd_chan = ch;
        rd_sel  = sel;
        tick();
        rd_req = 1'b0;
        chk({tag, "_ack"}, 32'(ack_a), 32'd1);
        chk({tag, "_q"}, rdq_a, exp_a);
        chk({tag, "_q_narrow"}, rdq_b, exp_b);
        tick();
        chk({tag, "_ack_drop"}, 32'(ack_a), 32'd0);
    endtask

    task automatic peek_heat(input string tag, input logic [6:0] idx, input logic [7:0] exp);
        hm_idx = idx;
        tick();
        chk(tag, 32'(hm_a), 32'(exp));
    endtask

    initial begin
        reset = 1'b1; err = '0; errbits = '0; decay_stb = 1'b0; clear = 1'b0;
        hm_idx = '0; rd_req = 1'b0; rd_chan = '0; rd_sel = '0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_hm", 32'(hm_a), 32'd0);
        chk("rst_ack", 32'(ack_a), 32'd0);
        chk("rst_rdq", rdq_a, 32'd0);
        chk("rst_any", 32'(any_a), 32'd0);
        tick();

        do_read("idle_sel0", 4'd0, 2'd0, 32'd0, 32'd0);
        do_read("idle_sel1", 4'd0, 2'd1, 32'd0, 32'd0);
        do_read("idle_sel2", 4'd0, 2'd2, 32'd0, 32'd0);

        // Three error pulses on channel 2, bits 0 and 15.
        err[2] = 1'b1;
        errbits[2*DW +: DW] = 16'h8001;
        repeat (3) tick();
        err = '0; errbits = '0;
        tick();
        do_read("ch2_evt", 4'd2, 2'd0, 32'd3, 32'd3);
        do_read("ch2_bits", 4'd2, 2'd1, 32'd6, 32'd6);
        do_read("ch2_mask", 4'd2, 2'd2, 32'h8001, 32'h8001);
        chk("any_set", 32'(any_a), 32'd1);
        peek_heat("heat32", 7'd32, 8'hFF);
        peek_heat("heat47", 7'd47, 8'hFF);
        peek_heat("heat33", 7'd33, 8'h00);
        peek_heat("heat31", 7'd31, 8'h00);
        peek_heat("heat_oob", 7'd100, 8'h00);

        // Decay: 10 strobes, then 54 more (64 total), then a few extra.
        hm_idx = 7'd32;
        decay_stb = 1'b1;
        repeat (10) tick();
        decay_stb = 1'b0;
        tick();
        tick();
        chk("decay10", 32'(hm_a), 32'hF5);
        chk("decay10_step4", 32'(hm_b), 32'(8'd215));
        decay_stb = 1'b1;
        repeat (54) tick();
        decay_stb = 1'b0;
        tick();
        tick();
        chk("decay64", 32'(hm_a), 32'hBF);
        chk("decay64_step4_zero", 32'(hm_b), 32'd0);
        decay_stb = 1'b1;
        repeat (3) tick();
        decay_stb = 1'b0;
        tick();
        tick();
        chk("decay_floor_nowrap", 32'(hm_b), 32'd0);

        // Channel 1 bit 0 (cell 16): load, decay to 0xFC, then err+decay.
        hm_idx = 7'd16;
        err[1] = 1'b1;
        errbits[1*DW +: DW] = 16'h0001;
        tick();
        err = '0; errbits = '0;
        decay_stb = 1'b1;
        repeat (3) tick();
        decay_stb = 1'b0;
        tick();
        tick();
        chk("ch1_decayed", 32'(hm_a), 32'hFC);
        err[1] = 1'b1;
        errbits[1*DW +: DW] = 16'h0001;
        decay_stb = 1'b1;
        tick();
        err = '0; errbits = '0; decay_stb = 1'b0;
        chk("hm_pre_update", 32'(hm_a), 32'hFC);
        tick();
        chk("err_beats_decay", 32'(hm_a), 32'hFF);

        // err and clear together on channel 3 bit 8 (cell 56).
        err[3] = 1'b1;
        errbits[3*DW +: DW] = 16'h0100;
        clear = 1'b1;
        tick();
        err = '0; errbits = '0; clear = 1'b0;
        chk("clear_any", 32'(any_a), 32'd0);
        do_read("clr_ch3_evt", 4'd3, 2'd0, 32'd0, 32'd0);
        do_read("clr_ch3_mask", 4'd3, 2'd2, 32'd0, 32'd0);
        do_read("clr_ch2_bits", 4'd2, 2'd1, 32'd0, 32'd0);
        peek_heat("clr_heat56", 7'd56, 8'hFF);

        // Saturation: 20 all-ones error pulses on channel 0.
        err[0] = 1'b1;
        errbits[0 +: DW] = 16'hFFFF;
        repeat (20) tick();
        err = '0; errbits = '0;
        tick();
        do_read("sat_evt", 4'd0, 2'd0, 32'd20, 32'd15);
        do_read("sat_bits", 4'd0, 2'd1, 32'd320, 32'd15);
        do_read("sat_mask", 4'd0, 2'd2, 32'hFFFF, 32'hFFFF);

        // Held request on an out-of-range channel: ack every other cycle.
        acks = 0;
        rd_req = 1'b1; rd_chan = 4'd7; rd_sel = 2'd0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (ack_a) acks++;
        end
        rd_req = 1'b0;
        chk("held_ack_count", 32'(acks), 32'd3);
        chk("oob_chan_rdq", rdq_a, 32'd0);
        tick();
        do_read("geometry", 4'd0, 2'd3, 32'h0510, 32'h0510);

        // Reset during ACK drops the ack and clears rd_q.
        rd_req = 1'b1; rd_chan = 4'd0; rd_sel = 2'd3;
        tick();
        rd_req = 1'b0;
        chk("pre_rst_ack", 32'(ack_a), 32'd1);
        reset = 1'b1;
        tick();
        chk("rst_in_ack_ack", 32'(ack_a), 32'd0);
        chk("rst_in_ack_rdq", rdq_a, 32'd0);
        reset = 1'b0;
        tick();
        chk("rst_in_ack_after", 32'(ack_a), 32'd0);

        // Reset coinciding with the accept edge yields no ack either.
        rd_req = 1'b1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rd_req = 1'b0;
        chk("rst_at_accept_ack", 32'(ack_a), 32'd0);
        chk("rst_at_accept_rdq", rdq_a, 32'd0);
        tick();
        chk("rst_at_accept_ack2", 32'(ack_a), 32'd0);
        peek_heat("rst_heat56", 7'd56, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
